// File: rtl/mem_beat_pkg.sv
// Shared FSM encoding and beat/line geometry for the 16-bit line beat bus.
// Used by the memory-side responder and reusable by the core's serializer.
package mem_beat_pkg;

  localparam int LG_D_WIDTH_DEF = 4;
  localparam int LG_CL_LEN_DEF  = 4;

  localparam int D_WIDTH    = 1 << LG_D_WIDTH_DEF;
  localparam int LINE_WIDTH = 8 << LG_CL_LEN_DEF;
  localparam int LG_N_WORDS = LG_CL_LEN_DEF + 3 - LG_D_WIDTH_DEF;
  localparam int N_WORDS    = 1 << LG_N_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    WCOLLECT,
    WCOMMIT,
    RFETCH,
    RSTREAM
  } state_t;

endpackage

// File: rtl/line_ram.sv
// Single-port synchronous line RAM with registered read data.
// Contents are deliberately not reset so data survives a responder reset.
module line_ram
  import mem_beat_pkg::*;
#(
  parameter int LG_DEPTH = 10,
  parameter int WIDTH    = LINE_WIDTH
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [LG_DEPTH-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [0:(1 << LG_DEPTH)-1];

  // Read data only updates on an explicit fetch so it stays stable while a line streams out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder: collects 8 write beats into a line, or streams a stored line out as 8 beats.
// Misaligned addresses use the aligned line and only flag rsp_err at completion.
module line_mem_responder
  import mem_beat_pkg::*;
#(
  parameter int LG_D_WIDTH = LG_D_WIDTH_DEF,
  parameter int LG_CL_LEN  = LG_CL_LEN_DEF,
  parameter int LG_DEPTH   = 10,
  parameter int M_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         is_write,
  input  logic [M_WIDTH-1:0]           addr,
  input  logic [(1 << LG_D_WIDTH)-1:0] d_out,
  input  logic                         d_out_valid,
  output logic [(1 << LG_D_WIDTH)-1:0] d_in,
  output logic                         d_in_valid,
  output logic                         rsp_done,
  output logic                         rsp_err
);

  localparam int BEAT_W   = 1 << LG_D_WIDTH;
  localparam int LINE_W   = 8 << LG_CL_LEN;
  localparam int WORDS_LG = LG_CL_LEN + 3 - LG_D_WIDTH;
  localparam int CNT_W    = WORDS_LG + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << WORDS_LG) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORDS_LG-1:0] word_sel;
  logic [LINE_W-1:0]   r_buf;
  logic [LINE_W-1:0]   rdata;
  logic [LG_DEPTH-1:0] line_idx;
  logic                r_err;
  logic                last_beat;
  logic                unused_addr_hi;

  assign word_sel       = r_cnt[WORDS_LG-1:0];
  assign last_beat      = (r_cnt == LAST_BEAT);
  assign unused_addr_hi = ^addr[M_WIDTH-1:LG_DEPTH+LG_CL_LEN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    d_in_valid = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = is_write ? WCOLLECT : RFETCH;
        end
      end
      WCOLLECT: begin
        if (d_out_valid && last_beat) begin
          state_nxt = WCOMMIT;
        end
      end
      WCOMMIT: begin
        rsp_done  = 1'b1;
        state_nxt = IDLE;
      end
      RFETCH: begin
        state_nxt = RSTREAM;
      end
      RSTREAM: begin
        d_in_valid = 1'b1;
        if (last_beat) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rsp_err = rsp_done & r_err;
  assign d_in    = d_in_valid ? rdata[word_sel*BEAT_W +: BEAT_W] : '0;

  // Request capture and beat counting; a reset mid-write drops the partial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_buf    <= '0;
      r_err    <= 1'b0;
      line_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_idx <= addr[LG_DEPTH+LG_CL_LEN-1:LG_CL_LEN];
            r_err    <= |addr[LG_CL_LEN-1:0];
            r_cnt    <= '0;
          end
        end
        WCOLLECT: begin
          if (d_out_valid) begin
            r_buf[word_sel*BEAT_W +: BEAT_W] <= d_out;
            r_cnt                            <= r_cnt + CNT_ONE;
          end
        end
        RSTREAM: begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  line_ram #(
    .LG_DEPTH(LG_DEPTH),
    .WIDTH   (LINE_W)
  ) u_line_ram (
    .clk  (clk),
    .we   (state == WCOMMIT),
    .re   (state == RFETCH),
    .addr (line_idx),
    .wdata(r_buf),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed plus randomized bench for line_mem_responder, checked against a line-level memory model.
module tb_line_mem_responder;
  import mem_beat_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_write = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] d_out = '0;
  logic        d_out_valid = 1'b0;
  logic        req_ready;
  logic [15:0] d_in;
  logic        d_in_valid;
  logic        rsp_done;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] model [int];

  always #5 clk = ~clk;

  line_mem_responder #(
    .LG_D_WIDTH(4),
    .LG_CL_LEN (4),
    .LG_DEPTH  (10),
    .M_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_write   (is_write),
    .addr       (addr),
    .d_out      (d_out),
    .d_out_valid(d_out_valid),
    .d_in       (d_in),
    .d_in_valid (d_in_valid),
    .rsp_done   (rsp_done),
    .rsp_err    (rsp_err)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lineOf(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  function automatic logic [15:0] beatOf(input logic [127:0] l, input int i);
    logic [127:0] sh;
    sh = l >> (16 * i);
    return sh[15:0];
  endfunction

  function automatic logic [127:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic doReset(input string tag);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_rst_valid"}, d_in_valid, 1'b0);
    checkOutput({tag, "_rst_done"}, rsp_done, 1'b0);
    checkOutput({tag, "_rst_ready"}, req_ready, 1'b1);
    req_valid   = 1'b0;
    d_out_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checkOutput({tag, "_post_ready"}, req_ready, 1'b1);
  endtask

  // One transaction starting in the current (IDLE) cycle; hold keeps req_valid high and
  // sprinkles stray write beats, abortBeat >= 0 asserts reset while that beat is on the bus.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [127:0] wline,
                               input int stallAfter, input int stallLen, input bit hold,
                               input int abortBeat);
    logic         expErr;
    int           idx;
    int           beat;
    int           stalls;
    logic [127:0] expLine;
    expErr  = (a % 32'd16) != 32'd0;
    idx     = lineOf(a);
    expLine = model.exists(idx) ? model[idx] : '0;
    req_valid   = 1'b1;
    is_write    = wr;
    addr        = a;
    d_out_valid = 1'b0;
    checkOutput("accept_ready", req_ready, 1'b1);
    tick();
    if (!hold) req_valid = 1'b0;
    if (wr) begin
      beat   = 0;
      stalls = 0;
      while (beat < 8) begin
        checkOutput("wr_busy_ready", req_ready, 1'b0);
        checkOutput("wr_busy_done", rsp_done, 1'b0);
        if (beat == stallAfter && stalls < stallLen) begin
          d_out_valid = 1'b0;
          d_out       = 16'($urandom);
          stalls++;
        end else begin
          d_out_valid = 1'b1;
          d_out       = beatOf(wline, beat);
          if (beat == abortBeat) begin
            doReset("wr_abort");
            return;
          end
          beat++;
        end
        tick();
      end
      d_out_valid = 1'b0;
      checkOutput("wr_commit_done", rsp_done, 1'b1);
      checkOutput("wr_commit_err", rsp_err, expErr);
      checkOutput("wr_commit_ready", req_ready, 1'b0);
      model[idx] = wline;
      tick();
    end else begin
      checkOutput("rd_fetch_valid", d_in_valid, 1'b0);
      checkOutput("rd_fetch_done", rsp_done, 1'b0);
      if (hold) begin
        d_out_valid = 1'b1;
        d_out       = 16'($urandom);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("rd_valid%0d", i), d_in_valid, 1'b1);
        checkOutput($sformatf("rd_beat%0d", i), d_in, beatOf(expLine, i));
        checkOutput($sformatf("rd_done%0d", i), rsp_done, (i == 7));
        checkOutput($sformatf("rd_err%0d", i), rsp_err, (i == 7) && expErr);
        if (i == abortBeat) begin
          doReset("rd_abort");
          return;
        end
        if (hold) begin
          d_out_valid = 1'($urandom);
          d_out       = 16'($urandom);
        end
        tick();
      end
    end
    d_out_valid = 1'b0;
    checkOutput("end_ready", req_ready, 1'b1);
    checkOutput("end_valid", d_in_valid, 1'b0);
    checkOutput("end_done", rsp_done, 1'b0);
  endtask

  initial begin
    logic [127:0] l40;
    logic [127:0] lx;
    logic [31:0]  a;
    int           pool [6];
    int           idx;

    pool = '{5, 17, 300, 1023, 512, 64};

    $display("[TB] reset checks");
    tick();
    tick();
    checkOutput("reset_ready", req_ready, 1'b1);
    checkOutput("reset_d_in", d_in, 16'h0);
    checkOutput("reset_valid", d_in_valid, 1'b0);
    checkOutput("reset_done", rsp_done, 1'b0);
    checkOutput("reset_err", rsp_err, 1'b0);
    reset = 1'b1;

    $display("[TB] write/read 0x40");
    l40 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    applyStimulus(1'b1, 32'h40, l40, -1, 0, 1'b0, -1);
    applyStimulus(1'b0, 32'h40, '0, -1, 0, 1'b0, -1);

    $display("[TB] stalled write 0x80");
    applyStimulus(1'b1, 32'h80, randLine(), 3, 3, 1'b0, -1);
    applyStimulus(1'b0, 32'h80, '0, -1, 0, 1'b0, -1);

    $display("[TB] misaligned and wrapped reads of line 0");
    applyStimulus(1'b1, 32'h0, randLine(), -1, 0, 1'b0, -1);
    applyStimulus(1'b0, 32'h4, '0, -1, 0, 1'b0, -1);
    applyStimulus(1'b0, 32'h4000, '0, -1, 0, 1'b0, -1);

    $display("[TB] reset during read stream");
    applyStimulus(1'b0, 32'h40, '0, -1, 0, 1'b0, 4);
    applyStimulus(1'b0, 32'h40, '0, -1, 0, 1'b0, -1);

    $display("[TB] reset during write collect");
    applyStimulus(1'b1, 32'h40, randLine(), -1, 0, 1'b0, 5);
    applyStimulus(1'b0, 32'h40, '0, -1, 0, 1'b0, -1);

    $display("[TB] held request, back-to-back");
    applyStimulus(1'b1, 32'hC0, randLine(), -1, 0, 1'b1, -1);
    applyStimulus(1'b0, 32'hC0, '0, -1, 0, 1'b1, -1);
    req_valid = 1'b0;
    tick();
    checkOutput("held_idle_ready", req_ready, 1'b1);
    checkOutput("held_idle_valid", d_in_valid, 1'b0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      idx = pool[$urandom_range(0, 5)];
      a   = (32'($urandom_range(0, 7)) << 14) | (32'(idx) << 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 15));
      if (!model.exists(lineOf(a)) || $urandom_range(0, 1) == 1) begin
        lx = randLine();
        applyStimulus(1'b1, a, lx, $urandom_range(0, 7), $urandom_range(0, 3), 1'b0, -1);
      end else begin
        applyStimulus(1'b0, a, '0, -1, 0, 1'b0, -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
